// File: rtl/dcache_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dcache_pkg - shared types and address-split constants for dcache |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package dcache_pkg;

  localparam int OFFSET_W = 5;
  localparam int INDEX_W  = 5;
  localparam int TAG_W    = 22;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_COMPARE   = 2'd1,
    S_WRITEBACK = 2'd2,
    S_ALLOCATE  = 2'd3
  } state_t;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

endpackage
`default_nettype wire

// File: rtl/dcache_tag_array.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dcache_tag_array - valid/dirty/tag storage, 1 comb read, 1 write |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module dcache_tag_array
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index,
  output tag_entry_t         rd_entry,
  input  logic               we,
  input  logic [INDEX_W-1:0] wr_index,
  input  tag_entry_t         wr_entry
);

  tag_entry_t entries_q [NUM_LINES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        entries_q[i] <= '0;
      end
    end else if (we) begin
      entries_q[wr_index] <= wr_entry;
    end
  end

  assign rd_entry = entries_q[rd_index];

endmodule
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dcache_ctrl - direct-mapped write-back/write-allocate data cache  |
// | Optional hit/miss counters with `define DCACHE_STATS_EN           |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 32,
  parameter int LINE_W    = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       p_addr_i,
  input  logic [31:0]       p_wdata_i,
  input  logic              p_read_i,
  input  logic              p_write_i,
  output logic [31:0]       p_rdata_o,
  output logic              p_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  state_t state_q, state_d;

  logic [TAG_W-1:0]   req_tag_q;
  logic [INDEX_W-1:0] req_idx_q;

  logic [TAG_W-1:0]          p_tag;
  logic [INDEX_W-1:0]        p_idx;
  logic [OFFSET_W-3:0]       p_word;
  logic                      req;
  logic [INDEX_W-1:0]        rd_idx;
  tag_entry_t                rd_entry;
  tag_entry_t                wr_entry;
  logic                      tag_we;
  logic                      hit;
  logic                      data_we;
  logic [LINE_W-1:0]         rd_line;
  logic                      unused_addr_bits;

  logic [LINE_W-1:0] data_q [NUM_LINES];

  assign p_tag            = p_addr_i[31:OFFSET_W+INDEX_W];
  assign p_idx            = p_addr_i[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign p_word           = p_addr_i[OFFSET_W-1:2];
  assign unused_addr_bits = ^p_addr_i[1:0];
  assign req              = p_read_i | p_write_i;

  // Outside IDLE the stalled pipeline may change p_*, so use the latched index.
  assign rd_idx  = (state_q == S_IDLE) ? p_idx : req_idx_q;
  assign rd_line = data_q[rd_idx];
  assign hit     = rd_entry.valid && (rd_entry.tag == p_tag);

  dcache_tag_array #(
    .NUM_LINES (NUM_LINES)
  ) u_tag_array (
    .clk      (clk_i),
    .rst      (rst_i),
    .rd_index (rd_idx),
    .rd_entry (rd_entry),
    .we       (tag_we),
    .wr_index (rd_idx),
    .wr_entry (wr_entry)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    p_stall_o   = 1'b0;
    p_rdata_o   = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    tag_we      = 1'b0;
    wr_entry    = '0;
    data_we     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (hit) begin
            p_rdata_o = rd_line[{p_word, 5'b0} +: 32];
            if (p_write_i) begin
              data_we  = 1'b1;
              tag_we   = 1'b1;
              wr_entry = '{valid: 1'b1, dirty: 1'b1, tag: p_tag};
            end
          end else begin
            p_stall_o = 1'b1;
            state_d   = (rd_entry.valid && rd_entry.dirty) ? S_WRITEBACK : S_ALLOCATE;
          end
        end
      end
      S_WRITEBACK: begin
        p_stall_o   = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {rd_entry.tag, req_idx_q, {OFFSET_W{1'b0}}};
        mem_wdata_o = rd_line;
        if (mem_ack_i) begin
          state_d = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        p_stall_o  = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = {req_tag_q, req_idx_q, {OFFSET_W{1'b0}}};
        if (mem_ack_i) begin
          tag_we   = 1'b1;
          wr_entry = '{valid: 1'b1, dirty: 1'b0, tag: req_tag_q};
          state_d  = S_COMPARE;
        end
      end
      S_COMPARE: begin
        p_stall_o = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_tag_q <= '0;
      req_idx_q <= '0;
    end else if (state_q == S_IDLE && req && !hit) begin
      req_tag_q <= p_tag;
      req_idx_q <= p_idx;
    end
  end

  // Line data is deliberately not reset; validity lives in the tag array.
  always_ff @(posedge clk_i) begin
    if (state_q == S_ALLOCATE && mem_ack_i) begin
      data_q[req_idx_q] <= mem_rdata_i;
    end else if (data_we) begin
      data_q[p_idx][{p_word, 5'b0} +: 32] <= p_wdata_i;
    end
  end

`ifdef DCACHE_STATS_EN
  logic post_refill_q;

  // The IDLE cycle right after COMPARE belongs to the miss, not to a hit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      post_refill_q <= 1'b0;
      hit_cnt_o     <= '0;
      miss_cnt_o    <= '0;
    end else begin
      post_refill_q <= (state_q == S_COMPARE);
      if (state_q == S_IDLE && req) begin
        if (hit && !post_refill_q && hit_cnt_o != '1) begin
          hit_cnt_o <= hit_cnt_o + 32'd1;
        end
        if (!hit && miss_cnt_o != '1) begin
          miss_cnt_o <= miss_cnt_o + 32'd1;
        end
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_dcache_ctrl - randomized bench with line-level cache model     |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_dcache_ctrl;

  localparam int NL = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   p_addr, p_wdata, p_rdata, mem_addr;
  logic          p_read, p_write, p_stall, mem_req, mem_we, mem_ack;
  logic [LW-1:0] mem_wdata, mem_rdata;
`ifdef DCACHE_STATS_EN
  logic [31:0]   hit_cnt, miss_cnt;
`endif

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: per-line state plus a sparse backing memory.
  bit            m_valid [NL];
  bit            m_dirty [NL];
  logic [21:0]   m_tag   [NL];
  logic [LW-1:0] m_data  [NL];
  logic [LW-1:0] mem_m   [logic [31:0]];
  int            exp_hits = 0;
  int            exp_miss = 0;

  always #5 clk = ~clk;

  dcache_ctrl #(
    .NUM_LINES (NL),
    .LINE_W    (LW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .p_addr_i    (p_addr),
    .p_wdata_i   (p_wdata),
    .p_read_i    (p_read),
    .p_write_i   (p_write),
    .p_rdata_o   (p_rdata),
    .p_stall_o   (p_stall),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .mem_ack_i   (mem_ack)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt_o   (hit_cnt),
    .miss_cnt_o  (miss_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] mem_line(input logic [31:0] la);
    logic [LW-1:0] l;
    if (mem_m.exists(la)) return mem_m[la];
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = (la + 32'(i * 4)) ^ 32'hC0DE_0000;
    return l;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
    end
    exp_hits = 0;
    exp_miss = 0;
  endtask

  task automatic check_stats(input string tag);
`ifdef DCACHE_STATS_EN
    chk({tag, "_hit_cnt"}, hit_cnt, exp_hits);
    chk({tag, "_miss_cnt"}, miss_cnt, exp_miss);
`endif
  endtask

  // One pipeline access; k / kw are the ack delays of refill / writeback.
  task automatic access(input logic [31:0] addr, input logic [31:0] wd,
                        input bit rd, input bit wr, input int k, input int kw);
    int          idx;
    int          w;
    logic [21:0] tg;
    logic [31:0] la, va;
    bit          hit;
    idx = int'(addr[9:5]);
    w   = int'(addr[4:2]);
    tg  = addr[31:10];
    la  = {addr[31:5], 5'b0};
    @(negedge clk);
    p_addr = addr; p_wdata = wd; p_read = rd; p_write = wr;
    #1;
    hit = m_valid[idx] && (m_tag[idx] == tg);
    if (!hit) begin
      chk("miss_stall", p_stall, 1);
      chk("miss_idle_req", mem_req, 0);
      exp_miss++;
      if (m_valid[idx] && m_dirty[idx]) begin
        va = {m_tag[idx], 5'(idx), 5'b0};
        for (int c = 0; c <= kw; c++) begin
          @(negedge clk);
          mem_ack = (c == kw);
          #1;
          chk("wb_stall", p_stall, 1);
          chk("wb_req", mem_req, 1);
          chk("wb_we", mem_we, 1);
          chk("wb_addr", mem_addr, va);
          chk("wb_wdata", mem_wdata, m_data[idx]);
        end
        mem_m[va] = m_data[idx];
      end
      for (int c = 0; c <= k; c++) begin
        @(negedge clk);
        mem_ack   = (c == k);
        mem_rdata = (c == k) ? mem_line(la) : {8{$urandom()}};
        #1;
        chk("alloc_stall", p_stall, 1);
        chk("alloc_req", mem_req, 1);
        chk("alloc_we", mem_we, 0);
        chk("alloc_addr", mem_addr, la);
      end
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      chk("cmp_stall", p_stall, 1);
      chk("cmp_req", mem_req, 0);
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tg;
      m_data[idx]  = mem_line(la);
      @(negedge clk);
      #1;
    end else begin
      exp_hits++;
    end
    chk("serve_stall", p_stall, 0);
    chk("serve_req", mem_req, 0);
    if (rd) chk("rdata", p_rdata, m_data[idx][w*32 +: 32]);
    if (wr) begin
      m_data[idx][w*32 +: 32] = wd;
      m_dirty[idx] = 1'b1;
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    p_read = 1'b0; p_write = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [21:0] tags [3];
    logic [4:0]  idxs [4];
    int          op;
    tags[0] = 22'h000; tags[1] = 22'h001; tags[2] = 22'h2A5;
    idxs[0] = 5'd0; idxs[1] = 5'd1; idxs[2] = 5'd7; idxs[3] = 5'd31;

    rst = 1'b1; p_addr = '0; p_wdata = '0; p_read = 1'b0; p_write = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    model_reset();
    @(negedge clk);
    #1;
    chk("rst_stall", p_stall, 0);
    chk("rst_rdata", p_rdata, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    check_stats("rst");
    @(negedge clk);
    rst = 1'b0;

    // Directed sequence: cold miss, write hit, dirty eviction, immediate ack.
    access(32'h0000_0040, '0, 1, 0, 3, 0);
    access(32'h0000_0044, 32'hDEAD_BEEF, 0, 1, 0, 0);
    access(32'h0000_0044, '0, 1, 0, 0, 0);
    chk("dir_rdata_44", p_rdata, 32'hDEAD_BEEF);
    access(32'h0000_0440, '0, 1, 0, 2, 1);
    chk("dir_wb_word1", mem_m[32'h40][63:32], 32'hDEAD_BEEF);
    access(32'h0000_1000, '0, 1, 0, 0, 0);
    idle_cycle();
    check_stats("dir");

    // Reset while ALLOCATE is in progress.
    @(negedge clk);
    p_addr = 32'h0000_0080; p_read = 1'b1;
    #1;
    chk("ra_stall", p_stall, 1);
    @(negedge clk);
    #1;
    chk("ra_req_before", mem_req, 1);
    chk("ra_addr_before", mem_addr, 32'h80);
    #1;
    rst = 1'b1; p_read = 1'b0;
    #1;
    chk("ra_req_async", mem_req, 0);
    chk("ra_addr_async", mem_addr, 0);
    chk("ra_stall_async", p_stall, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = {8{32'hBAD0_BAD0}};
    #1;
    chk("stray_req", mem_req, 0);
    chk("stray_stall", p_stall, 0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("stray_after_req", mem_req, 0);
    access(32'h0000_0080, '0, 1, 0, 1, 0);
    check_stats("post_rst");

    // Randomized traffic over a few conflicting tags and indices.
    for (int n = 0; n < 80; n++) begin
      a  = {tags[$urandom_range(0, 2)], idxs[$urandom_range(0, 3)],
            3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      op = $urandom_range(0, 2);
      access(a, $urandom(), op != 1, op != 0, $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();
    @(negedge clk);
    #1;
    chk("end_stall", p_stall, 0);
    chk("end_rdata", p_rdata, 0);
    check_stats("end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
